sha256_chunk_loop_unit: RTL and testbench
=========================================

Name:
sha256_chunk_loop_unit

Overview:
- Iterative SHA-256 compression engine: processes one pre-padded 512-bit message chunk against a 256-bit chaining hash and returns the updated hash.
- One round per clock; 64 rounds plus one finalisation cycle.
- Sits after the message padder. Chains multi-block messages by feeding hash_out back into hash_in.
- The standard initial hash value (IV) constant is provided by a compile-time option.

Parameters:
- none. The round constants K[0..63] and the IV are fixed FIPS 180-4 values.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- hash_in  input  256  chaining hash H0..H7; H0 = bits [255:224].
- chunk_in  input  512  padded message block; W0 = bits [511:480], big-endian words.
- chunk_flag  input  1  start strobe, sampled only in IDLE.
- hash_out  output  256  result hash, same word order as hash_in.
- hash_out_valid  output  1  one-cycle pulse when hash_out is updated.

Behaviour:
- Reset: state=IDLE, round counter=0, hash_out=0, hash_out_valid=0, all working/schedule registers=0.
- States: IDLE, ROUND, FINAL.
- IDLE with chunk_flag=1 (edge E0):
  - latch hash_in and chunk_in;
  - a..h <= H0..H7;
  - 16-word schedule window <= W0..W15;
  - counter=0; go to ROUND.
- ROUND (edges E1..E64): one compression round t per edge, using K[t] and W[t].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - All sums are mod 2^32.
  - W[t] for t≥16 = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed on the fly in a shifting 16-word window. No 64-word storage.
  - After round 63, go to FINAL.
- FINAL (edge E65):
  - hash_out <= {H0+a, …, H7+h}, each 32-bit add mod 2^32, using the latched hash;
  - hash_out_valid <= 1;
  - go to IDLE.
- hash_out_valid is cleared on the next edge.
- hash_out holds its value until the next FINAL or reset.
- Latency: hash_out_valid is high for the cycle following the 65th edge after the capture edge.
- chunk_flag in ROUND/FINAL is ignored: no queuing, no abort.
- chunk_flag during the valid-high cycle (state is IDLE) is accepted, so back-to-back chunks run with no dead cycle.
- hash_in and chunk_in may change freely after the capture edge.
- rst mid-operation aborts the computation and restores reset values. No valid pulse is produced.
- rst and chunk_flag in the same cycle: rst wins.
- No padding or length handling inside the block.

Optional Feature:
- Macro SHA256_INI_HASH_EN.
- Defined: adds output port hash_ini[255:0], a constant (purely combinational) IV:
  6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 (H0 at MSBs).
  It can be wired directly to hash_in for the first block.
- Undefined: port absent; the caller supplies the IV. Core behaviour is identical.

Test Plan:
- IV on hash_in; chunk_in = 616263800…0018 ("abc"); one-cycle chunk_flag -> single valid pulse 66 cycles after the capture edge; hash_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- IV; chunk_in = 80000000…00000000 (empty message) -> hash_out = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 2 ends …000001c0):
  - block 1 with IV;
  - block 2 with hash_in = first hash_out, flag asserted in the valid cycle;
  - -> final hash_out = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- chunk_flag re-pulsed at cycles 10 and 40 of an "abc" run -> ignored; exactly one valid pulse at the normal time; "abc" digest.
- rst asserted at round 30, then a new "abc" start -> no valid from the aborted run; hash_out=0 after reset; correct "abc" digest from the restarted run.
- SHA256_INI_HASH_EN defined -> hash_ini = 6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19 immediately, including during reset.

Source files
------------

// File: rtl/sha256_chunk_loop_unit.sv
// ---------------------------------------------------------------------------
// sha256_chunk_loop_unit
//
// Iterative SHA-256 compression engine. Takes one pre-padded 512-bit chunk
// and a 256-bit chaining hash, runs one compression round per clock (64
// rounds) plus one finalisation cycle, and presents the updated hash.
// Multi-block messages are chained by feeding hash_out back into hash_in.
//
// Ports:
//   clk            in   1    system clock, rising edge
//   rst            in   1    synchronous, active-high reset
//   hash_in        in   256  chaining hash H0..H7, H0 in bits [255:224]
//   chunk_in       in   512  padded block, W0 in bits [511:480]
//   chunk_flag     in   1    start strobe, only honoured in IDLE
//   hash_out       out  256  result hash, same word order as hash_in
//   hash_out_valid out  1    one-cycle pulse when hash_out is updated
//   hash_ini       out  256  FIPS 180-4 initial hash value (constant), only
//                            present when SHA256_INI_HASH_EN is defined
//
// Compile-time option:
//   SHA256_INI_HASH_EN  adds the hash_ini output port.
// ---------------------------------------------------------------------------
module sha256_chunk_loop_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] hash_in,
    input  logic [511:0] chunk_in,
    input  logic         chunk_flag,
    output logic [255:0] hash_out,
    output logic         hash_out_valid
`ifdef SHA256_INI_HASH_EN
    ,
    output logic [255:0] hash_ini
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---- SHA-256 logical functions (rotates written as bit concatenations)
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t       state;
    state_t       state_nxt;
    logic [5:0]   round_cnt;
    logic [255:0] hash_lat;
    logic [31:0]  a, b, c, d, e, f, g, h;
    // Schedule window: w[0] is W[t] for the current round, w[15] is W[t+15].
    logic [31:0]  w [0:15];

    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [31:0]  w_new;

    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]; shifted into w[15]
    // each round so only 16 words are ever stored. Words produced past
    // W[63] during the last rounds are never consumed.
    always_comb begin
        t1    = h + big_sigma1(e) + ch(e, f, g) + K[round_cnt] + w[0];
        t2    = big_sigma0(a) + maj(a, b, c);
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    // ---- FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM next-state logic
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (chunk_flag) state_nxt = ROUND;
            ROUND:   if (round_cnt == 6'd63) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- Datapath: capture, rounds, finalisation
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the round update samples the pre-edge values of a..h and w[].
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the schedule window is a register bank, not a RAM, so it
            // is cleared along with everything else for a deterministic state.
            round_cnt      <= '0;
            hash_lat       <= '0;
            hash_out       <= '0;
            hash_out_valid <= 1'b0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            hash_out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (chunk_flag) begin
                        hash_lat  <= hash_in;
                        {a, b, c, d, e, f, g, h} <= hash_in;
                        for (int i = 0; i < 16; i++) w[i] <= chunk_in[511 - 32*i -: 32];
                        round_cnt <= '0;
                    end
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15]     <= w_new;
                    round_cnt <= round_cnt + 6'd1;
                end
                FINAL: begin
                    hash_out <= {hash_lat[255:224] + a, hash_lat[223:192] + b,
                                 hash_lat[191:160] + c, hash_lat[159:128] + d,
                                 hash_lat[127:96]  + e, hash_lat[95:64]   + f,
                                 hash_lat[63:32]   + g, hash_lat[31:0]    + h};
                    hash_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_INI_HASH_EN
    assign hash_ini = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`endif

endmodule

// File: tb/tb_sha256_chunk_loop_unit.sv
// ---------------------------------------------------------------------------
// tb_sha256_chunk_loop_unit
//
// Scoreboard bench for sha256_chunk_loop_unit. Each accepted start pushes the
// expected digest and the expected valid cycle; a negedge monitor pops and
// compares whenever hash_out_valid is seen. Expected digests are the
// published FIPS 180-4 example values.
// ---------------------------------------------------------------------------
module tb_sha256_chunk_loop_unit;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] CHUNK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] CHUNK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] CHUNK_TWO_1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] CHUNK_TWO_2 = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] hash_in = '0;
    logic [511:0] chunk_in = '0;
    logic         chunk_flag = 1'b0;
    logic [255:0] hash_out;
    logic         hash_out_valid;
`ifdef SHA256_INI_HASH_EN
    logic [255:0] hash_ini;
`endif

    sha256_chunk_loop_unit dut (
        .clk            (clk),
        .rst            (rst),
        .hash_in        (hash_in),
        .chunk_in       (chunk_in),
        .chunk_flag     (chunk_flag),
        .hash_out       (hash_out),
        .hash_out_valid (hash_out_valid)
`ifdef SHA256_INI_HASH_EN
        ,
        .hash_ini       (hash_ini)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        tag;
        logic [255:0] digest;
        bit           chk;
        int unsigned  due;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Call at a negedge: drives a one-cycle start strobe captured at the next
    // posedge and records what the DUT owes us 65 edges after that.
    task automatic start(input string tag, input logic [255:0] h, input logic [511:0] ck,
                         input logic [255:0] dig, input bit chk);
        exp_t e;
        hash_in    = h;
        chunk_in   = ck;
        chunk_flag = 1'b1;
        e.tag    = tag;
        e.digest = dig;
        e.chk    = chk;
        e.due    = cyc + 66;
        sb.push_back(e);
        @(negedge clk);
        chunk_flag = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Monitor: every valid pulse must be owed by the scoreboard, on time.
    always @(negedge clk) begin
        if (!rst && hash_out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_cycle"}, cyc, e.due);
                if (e.chk) check({e.tag, "_digest"}, hash_out, e.digest);
            end
        end
    end

    initial begin
        int n;
        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_hash_out", hash_out, 0);
        check("rst_valid", hash_out_valid, 0);
`ifdef SHA256_INI_HASH_EN
        check("hash_ini_in_reset", hash_ini, IV);
`endif
        rst = 1'b0;
        @(negedge clk);

        // ---- single-block "abc"
        start("abc", IV, CHUNK_ABC, DIG_ABC, 1'b1);
        drain("abc_drain");
        check("abc_hold", hash_out, DIG_ABC);

        // ---- empty message
        @(negedge clk);
        start("empty", IV, CHUNK_EMPTY, DIG_EMPTY, 1'b1);
        drain("empty_drain");

        // ---- two-block message, block 2 started in the valid cycle
        @(negedge clk);
        start("two_b1", IV, CHUNK_TWO_1, '0, 1'b0);
        n = 0;
        while (!hash_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("two_b1_seen", hash_out_valid, 1);
        start("two_b2", hash_out, CHUNK_TWO_2, DIG_TWO, 1'b1);
        hash_in  = '0;
        chunk_in = '0;
        drain("two_drain");

        // ---- re-pulsed chunk_flag mid-run must be ignored
        @(negedge clk);
        start("repulse", IV, CHUNK_ABC, DIG_ABC, 1'b1);
        chunk_in = CHUNK_EMPTY;
        repeat (9) @(negedge clk);
        chunk_flag = 1'b1;
        @(negedge clk);
        chunk_flag = 1'b0;
        repeat (29) @(negedge clk);
        chunk_flag = 1'b1;
        @(negedge clk);
        chunk_flag = 1'b0;
        drain("repulse_drain");

        // ---- reset mid-run aborts; restart completes normally
        @(negedge clk);
        start("aborted", IV, CHUNK_ABC, DIG_ABC, 1'b1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        chunk_flag = 1'b1;   // rst must win over a coincident start
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chunk_flag = 1'b0;
        check("abort_hash_out", hash_out, 0);
        check("abort_valid", hash_out_valid, 0);
`ifdef SHA256_INI_HASH_EN
        check("hash_ini_after_reset", hash_ini, IV);
`endif
        // Idle past where the aborted run would have finished; the monitor
        // flags any valid pulse here because the scoreboard is empty.
        repeat (70) @(negedge clk);
        check("abort_quiet_hash", hash_out, 0);
        start("restart", IV, CHUNK_ABC, DIG_ABC, 1'b1);
        drain("restart_drain");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
